// File: rtl/fault_diagnoser_if.sv
// rtl/fault_diagnoser_if.sv - dictionary load, observation and diagnosis result bundle
interface fault_diagnoser_if #(
    parameter int TST_COUNT = 6,
    parameter int DEPTH     = 32,
    parameter int ID_W      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 dict_wr;
    logic [ID_W-1:0]      dict_id;
    logic [TST_COUNT-1:0] dict_syn;
    logic                 dict_ready;
    logic                 dict_clr;
    logic [CW-1:0]        dict_count;

    logic                 obs_valid;
    logic                 obs_good;
    logic                 obs_dut;
    logic                 obs_ready;

    logic                 diag_valid;
    logic [TST_COUNT-1:0] diag_syn;
    logic [ID_W-1:0]      diag_id;
    logic [CW-1:0]        diag_hits;
    logic                 fault_free;
    logic                 undiagnosed;

    modport master (
        output dict_wr, dict_id, dict_syn, dict_clr,
        output obs_valid, obs_good, obs_dut,
        input  dict_ready, dict_count, obs_ready,
        input  diag_valid, diag_syn, diag_id, diag_hits, fault_free, undiagnosed
    );

    modport slave (
        input  dict_wr, dict_id, dict_syn, dict_clr,
        input  obs_valid, obs_good, obs_dut,
        output dict_ready, dict_count, obs_ready,
        output diag_valid, diag_syn, diag_id, diag_hits, fault_free, undiagnosed
    );
endinterface

// File: rtl/fault_diagnoser.sv
// rtl/fault_diagnoser.sv - stuck-at fault dictionary lookup from observed test syndrome
module fault_diagnoser #(
    parameter int TST_COUNT = 6,
    parameter int DEPTH     = 32,
    parameter int ID_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fault_diagnoser_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (TST_COUNT > 1) ? $clog2(TST_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SEARCH, REPORT} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [TST_COUNT-1:0] syn;
    logic [CW-1:0]        count;
    logic [CW-1:0]        ptr;
    logic [CW-1:0]        hits;
    logic                 found;
    logic [ID_W-1:0]      first_id;

    logic [ID_W-1:0]      mem_id  [DEPTH];
    logic [TST_COUNT-1:0] mem_syn [DEPTH];

    logic                 loading;
    logic                 wr_en;

    // Loading (dictionary writes and observations) is only open before a search starts
    always_comb begin
        loading        = (state == IDLE) || (state == COLLECT);
        bus.dict_ready = loading && (count < CW'(DEPTH));
        bus.obs_ready  = loading;
        wr_en          = bus.dict_ready && bus.dict_wr && !bus.dict_clr;
        bus.dict_count = count;
    end

    // Dictionary storage; contents are meaningful only below count, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_id[count[AW-1:0]]  <= bus.dict_id;
            mem_syn[count[AW-1:0]] <= bus.dict_syn;
        end
    end

    // Control FSM: collect syndrome, linear search over stored entries, one-cycle report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            syn             <= '0;
            count           <= '0;
            ptr             <= '0;
            hits            <= '0;
            found           <= 1'b0;
            first_id        <= '0;
            bus.diag_valid  <= 1'b0;
            bus.diag_syn    <= '0;
            bus.diag_id     <= '0;
            bus.diag_hits   <= '0;
            bus.fault_free  <= 1'b0;
            bus.undiagnosed <= 1'b0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (bus.dict_clr) begin
                        count <= '0;
                    end else if (wr_en) begin
                        count <= count + CW'(1);
                    end
                    if (bus.obs_valid) begin
                        syn[idx] <= bus.obs_good ^ bus.obs_dut;
                        if (idx == IW'(TST_COUNT - 1)) begin
                            idx      <= '0;
                            ptr      <= '0;
                            hits     <= '0;
                            found    <= 1'b0;
                            first_id <= '0;
                            state    <= SEARCH;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= COLLECT;
                        end
                    end
                end
                SEARCH: begin
                    // ptr reaching count means every stored entry has been compared
                    if (ptr == count) begin
                        state           <= REPORT;
                        bus.diag_valid  <= 1'b1;
                        bus.diag_syn    <= syn;
                        bus.diag_id     <= first_id;
                        bus.diag_hits   <= hits;
                        bus.fault_free  <= (syn == '0);
                        bus.undiagnosed <= (syn != '0) && (hits == '0);
                    end else begin
                        if (mem_syn[ptr[AW-1:0]] == syn) begin
                            hits <= hits + CW'(1);
                            if (!found) begin
                                found    <= 1'b1;
                                first_id <= mem_id[ptr[AW-1:0]];
                            end
                        end
                        ptr <= ptr + CW'(1);
                    end
                end
                REPORT: begin
                    bus.diag_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fault_diagnoser.sv
// tb/tb_fault_diagnoser.sv - directed self-checking bench for fault_diagnoser
module tb_fault_diagnoser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fault_diagnoser_if #(.TST_COUNT(6), .DEPTH(32), .ID_W(8)) bus ();

    fault_diagnoser #(.TST_COUNT(6), .DEPTH(32), .ID_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dict_wr   = 1'b0;
        bus.dict_id   = '0;
        bus.dict_syn  = '0;
        bus.dict_clr  = 1'b0;
        bus.obs_valid = 1'b0;
        bus.obs_good  = 1'b0;
        bus.obs_dut   = 1'b0;
    endtask

    task automatic write_entry(input logic [7:0] id, input logic [5:0] s);
        bus.dict_wr  = 1'b1;
        bus.dict_id  = id;
        bus.dict_syn = s;
        tick();
        bus.dict_wr  = 1'b0;
    endtask

    task automatic clear_dict();
        bus.dict_clr = 1'b1;
        tick();
        bus.dict_clr = 1'b0;
    endtask

    task automatic load_std();
        clear_dict();
        write_entry(8'h02, 6'b000101);
        write_entry(8'h03, 6'b110000);
        write_entry(8'h07, 6'b000101);
        write_entry(8'h09, 6'b001000);
    endtask

    task automatic send_obs(input logic [5:0] s);
        for (int i = 0; i < 6; i++) begin
            bus.obs_valid = 1'b1;
            bus.obs_good  = 1'($urandom_range(0, 1));
            bus.obs_dut   = bus.obs_good ^ s[i];
            tick();
        end
        bus.obs_valid = 1'b0;
    endtask

    task automatic wait_diag(output int lat);
        lat = 0;
        while (bus.diag_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.diag_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.diag_valid); end
        checks++; if (bus.dict_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.dict_count); end
        checks++; if (bus.dict_ready !== 1'b1) begin errors++; $display("FAIL reset_dict_ready: got %0b expected 1", bus.dict_ready); end
        checks++; if (bus.obs_ready !== 1'b1) begin errors++; $display("FAIL reset_obs_ready: got %0b expected 1", bus.obs_ready); end
        checks++; if ({bus.diag_syn, bus.diag_id, bus.diag_hits, bus.fault_free, bus.undiagnosed} !== '0) begin errors++; $display("FAIL reset_outputs: got syn %0h id %0h hits %0d ff %0b und %0b expected all 0", bus.diag_syn, bus.diag_id, bus.diag_hits, bus.fault_free, bus.undiagnosed); end
    endtask

    task automatic test_match();
        int lat;
        load_std();
        checks++; if (bus.dict_count !== 6'd4) begin errors++; $display("FAIL match_count: got %0d expected 4", bus.dict_count); end
        send_obs(6'b000101);
        wait_diag(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL match_latency: got %0d expected 5", lat); end
        checks++; if (bus.diag_id !== 8'h02) begin errors++; $display("FAIL match_id: got %0h expected 02", bus.diag_id); end
        checks++; if (bus.diag_hits !== 6'd2) begin errors++; $display("FAIL match_hits: got %0d expected 2", bus.diag_hits); end
        checks++; if (bus.diag_syn !== 6'b000101) begin errors++; $display("FAIL match_syn: got %b expected 000101", bus.diag_syn); end
        checks++; if ({bus.fault_free, bus.undiagnosed} !== 2'b00) begin errors++; $display("FAIL match_flags: got %b expected 00", {bus.fault_free, bus.undiagnosed}); end
        tick();
        checks++; if (bus.diag_valid !== 1'b0) begin errors++; $display("FAIL match_pulse: got %0b expected 0", bus.diag_valid); end
        checks++; if (bus.diag_id !== 8'h02) begin errors++; $display("FAIL match_hold: got %0h expected 02", bus.diag_id); end
    endtask

    task automatic test_fault_free();
        int lat;
        send_obs(6'b000000);
        wait_diag(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL ff_latency: got %0d expected 5", lat); end
        checks++; if (bus.diag_syn !== 6'b0) begin errors++; $display("FAIL ff_syn: got %b expected 000000", bus.diag_syn); end
        checks++; if (bus.fault_free !== 1'b1) begin errors++; $display("FAIL ff_flag: got %0b expected 1", bus.fault_free); end
        checks++; if (bus.diag_hits !== 6'd0) begin errors++; $display("FAIL ff_hits: got %0d expected 0", bus.diag_hits); end
        checks++; if (bus.diag_id !== 8'h00) begin errors++; $display("FAIL ff_id: got %0h expected 00", bus.diag_id); end
        checks++; if (bus.undiagnosed !== 1'b0) begin errors++; $display("FAIL ff_undiag: got %0b expected 0", bus.undiagnosed); end
        tick();
    endtask

    task automatic test_no_match();
        int lat;
        send_obs(6'b111111);
        wait_diag(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL nomatch_latency: got %0d expected 5", lat); end
        checks++; if (bus.undiagnosed !== 1'b1) begin errors++; $display("FAIL nomatch_undiag: got %0b expected 1", bus.undiagnosed); end
        checks++; if (bus.diag_hits !== 6'd0) begin errors++; $display("FAIL nomatch_hits: got %0d expected 0", bus.diag_hits); end
        checks++; if (bus.fault_free !== 1'b0) begin errors++; $display("FAIL nomatch_ff: got %0b expected 0", bus.fault_free); end
        tick();
    endtask

    task automatic test_empty();
        int lat;
        clear_dict();
        checks++; if (bus.dict_count !== 6'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", bus.dict_count); end
        send_obs(6'b101010);
        wait_diag(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency: got %0d expected 1", lat); end
        checks++; if (bus.undiagnosed !== 1'b1) begin errors++; $display("FAIL empty_undiag: got %0b expected 1", bus.undiagnosed); end
        checks++; if (bus.diag_syn !== 6'b101010) begin errors++; $display("FAIL empty_syn: got %b expected 101010", bus.diag_syn); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [5:0] s;
        s = 6'b110011;
        write_entry(8'h11, 6'b000001);
        for (int i = 0; i < 6; i++) begin
            bus.obs_valid = 1'b1;
            bus.obs_good  = 1'b1;
            bus.obs_dut   = ~s[i];
            if (i == 5) begin
                bus.dict_wr  = 1'b1;
                bus.dict_id  = 8'h22;
                bus.dict_syn = s;
            end
            tick();
        end
        idle_inputs();
        checks++; if (bus.dict_count !== 6'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", bus.dict_count); end
        wait_diag(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", lat); end
        checks++; if (bus.diag_id !== 8'h22) begin errors++; $display("FAIL b2b_id: got %0h expected 22", bus.diag_id); end
        checks++; if (bus.diag_hits !== 6'd1) begin errors++; $display("FAIL b2b_hits: got %0d expected 1", bus.diag_hits); end
        tick();
    endtask

    task automatic test_full();
        int lat;
        int extra;
        clear_dict();
        for (int i = 0; i < 33; i++) begin
            if (i < 32) begin
                checks++; if (bus.dict_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %0b expected 1", i, bus.dict_ready); end
            end
            write_entry(8'(8'h40 + i), 6'(i));
        end
        checks++; if (bus.dict_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %0b expected 0", bus.dict_ready); end
        checks++; if (bus.dict_count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", bus.dict_count); end
        send_obs(6'd7);
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            bus.dict_wr   = 1'b1;
            bus.dict_id   = 8'hEE;
            bus.dict_syn  = 6'd7;
            bus.obs_valid = 1'b1;
            bus.obs_good  = 1'b0;
            bus.obs_dut   = 1'b1;
            #1;
            checks++; if (bus.obs_ready !== 1'b0) begin errors++; $display("FAIL search_obs_ready: got %0b expected 0", bus.obs_ready); end
            checks++; if (bus.dict_ready !== 1'b0) begin errors++; $display("FAIL search_dict_ready: got %0b expected 0", bus.dict_ready); end
            tick();
            extra++;
            checks++; if (bus.dict_count !== 6'd32) begin errors++; $display("FAIL search_count: got %0d expected 32", bus.dict_count); end
        end
        idle_inputs();
        wait_diag(lat);
        lat = lat + extra;
        checks++; if (lat !== 33) begin errors++; $display("FAIL full_latency: got %0d expected 33", lat); end
        checks++; if (bus.diag_id !== 8'h47) begin errors++; $display("FAIL full_id: got %0h expected 47", bus.diag_id); end
        checks++; if (bus.diag_hits !== 6'd1) begin errors++; $display("FAIL full_hits: got %0d expected 1", bus.diag_hits); end
        checks++; if (bus.diag_syn !== 6'd7) begin errors++; $display("FAIL full_syn: got %b expected 000111", bus.diag_syn); end
        tick();
    endtask

    task automatic test_reset_mid_search();
        int lat;
        int pulses;
        load_std();
        send_obs(6'b001000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dict_count !== 6'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.dict_count); end
        checks++; if ({bus.diag_valid, bus.diag_syn, bus.diag_id, bus.diag_hits, bus.fault_free, bus.undiagnosed} !== '0) begin errors++; $display("FAIL midrst_outputs: got v %0b syn %0h id %0h hits %0d expected all 0", bus.diag_valid, bus.diag_syn, bus.diag_id, bus.diag_hits); end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.diag_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", pulses); end
        checks++; if (bus.obs_ready !== 1'b1) begin errors++; $display("FAIL midrst_obs_ready: got %0b expected 1", bus.obs_ready); end
        load_std();
        send_obs(6'b001000);
        wait_diag(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
        checks++; if (bus.diag_id !== 8'h09) begin errors++; $display("FAIL midrst_id: got %0h expected 09", bus.diag_id); end
        checks++; if (bus.diag_hits !== 6'd1) begin errors++; $display("FAIL midrst_hits: got %0d expected 1", bus.diag_hits); end
        tick();
    endtask

    initial begin
        test_reset();
        test_match();
        test_fault_free();
        test_no_match();
        test_empty();
        test_back_to_back();
        test_full();
        test_reset_mid_search();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
